// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, byte width and
// the default requester-idle timeout.
package uart_tx_arb_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage : uart_tx_arb_pkg

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req      - request vector
//   ptr      - index of the previous winner (lowest priority this round)
//   pick_oh  - one-hot winner, zero when no request
//   pick_idx - binary index of the winner
//   pick_any - at least one request present
module uart_tx_arb_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick_oh,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_any
);

    // Search upward from ptr+1, wrapping modulo N; first hit wins.
    always_comb begin : p_pick
        int unsigned cand;
        logic [N-1:0] req_sh;
        cand     = 0;
        req_sh   = '0;
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand   = (32'(ptr) + i) % N;
            req_sh = req >> cand;
            if (!pick_any && req_sh[0]) begin
                pick_any = 1'b1;
                pick_oh  = N'(1) << cand;
                pick_idx = PTR_W'(cand);
            end
        end
    end

endmodule : uart_tx_arb_rr_pick

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX data register among NUM_REQ
// byte-stream requesters. A grant lasts for a whole message (up to the byte
// flagged last) or until the owner stays idle for TIMEOUT_CYCLES cycles.
// Ports:
//   ACLK, ARESETn   - clock, asynchronous active-low reset
//   req_valid/data/last/ready - per-requester byte stream (ready is combinational)
//   tx_ready        - UART TX can take one byte
//   tx_data_reg_wr  - one-cycle write strobe, tx_data - byte written
//   grant           - one-hot owner, busy - message in progress
//   timeout_evt     - one-cycle pulse when a grant is revoked by timeout
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W           = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_ready,
    output logic                           tx_data_reg_wr,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           timeout_evt
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q,   state_d;
    logic [NUM_REQ-1:0]     grant_q,   grant_d;
    logic [PTR_W-1:0]       gidx_q,    gidx_d;
    logic [PTR_W-1:0]       rr_ptr_q,  rr_ptr_d;
    logic                   busy_q,    busy_d;
    logic                   wr_q,      wr_d;
    logic                   last_q,    last_d;
    logic                   to_evt_q,  to_evt_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [TO_W-1:0]        to_cnt_q,  to_cnt_d;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_any;

    logic                   sel_valid;
    logic                   sel_last;
    logic [UART_DATA_W-1:0] sel_data;
    logic                   accept;

    uart_tx_arb_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // Owner's stream, selected through the one-hot grant.
    always_comb begin
        sel_valid = |(grant_q & req_valid);
        sel_last  = |(grant_q & req_last);
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data = req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    // Bytes are only taken in SEND, so GAP gives the UART a cycle to update tx_ready.
    always_comb begin
        accept    = (state_q == ST_SEND) && sel_valid && tx_ready;
        req_ready = ((state_q == ST_SEND) && tx_ready) ? (grant_q & req_valid) : '0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        last_d    = last_q;
        to_evt_d  = 1'b0;
        tx_data_d = tx_data_q;
        to_cnt_d  = to_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_oh;
                    gidx_d   = pick_idx;
                    busy_d   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    tx_data_d = sel_data;
                    wr_d      = 1'b1;
                    last_d    = sel_last;
                    to_cnt_d  = '0;
                    state_d   = ST_GAP;
                end else if (!sel_valid) begin
                    // Only an idle owner counts; UART backpressure holds the count.
                    if (to_cnt_q == TO_LIMIT) begin
                        to_evt_d = 1'b1;
                        grant_d  = '0;
                        busy_d   = 1'b0;
                        rr_ptr_d = gidx_q;
                        to_cnt_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (last_q) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = gidx_q;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= PTR_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            last_q    <= 1'b0;
            to_evt_q  <= 1'b0;
            tx_data_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            last_q    <= last_d;
            to_evt_q  <= to_evt_d;
            tx_data_q <= tx_data_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign tx_data_reg_wr = wr_q;
    assign tx_data        = tx_data_q;
    assign grant          = grant_q;
    assign busy           = busy_q;
    assign timeout_evt    = to_evt_q;

endmodule : uart_tx_arb

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: a 2-requester instance (A) for the
// message, backpressure, timeout and reset scenarios, and a 4-requester
// instance (B) for round-robin fairness.
module tb_uart_tx_arb;

    typedef struct {
        logic [7:0]  data;
        int unsigned owner;
        int unsigned gap;   // expected cycles since previous strobe, 0 = don't care
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [1:0]  a_valid, a_last, a_ready, a_grant;
    logic [15:0] a_data;
    logic        tx_ready, a_wr, a_busy, a_tevt;
    logic [7:0]  a_tx_data;

    logic [3:0]  b_valid, b_last, b_ready, b_grant;
    logic [31:0] b_data;
    logic        b_tx_ready, b_wr, b_busy, b_tevt;
    logic [7:0]  b_tx_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [1:0]  acc;

    int unsigned cyc_a = 0, last_a = 0, cyc_b = 0, last_b = 0;
    int unsigned cnt_b[4];
    exp_t        ea, eb;

    uart_tx_arb #(.NUM_REQ(2), .TIMEOUT_CYCLES(255), .TO_W(8)) dut_a (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(a_valid), .req_data(a_data), .req_last(a_last), .req_ready(a_ready),
        .tx_ready(tx_ready), .tx_data_reg_wr(a_wr), .tx_data(a_tx_data),
        .grant(a_grant), .busy(a_busy), .timeout_evt(a_tevt)
    );

    uart_tx_arb #(.NUM_REQ(4), .TIMEOUT_CYCLES(255), .TO_W(8)) dut_b (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(b_valid), .req_data(b_data), .req_last(b_last), .req_ready(b_ready),
        .tx_ready(b_tx_ready), .tx_data_reg_wr(b_wr), .tx_data(b_tx_data),
        .grant(b_grant), .busy(b_busy), .timeout_evt(b_tevt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic push_a(input logic [7:0] d, input int unsigned o, input int unsigned g);
        exp_t e;
        e.data = d; e.owner = o; e.gap = g;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input int unsigned o, input int unsigned g);
        exp_t e;
        e.data = d; e.owner = o; e.gap = g;
        exp_b.push_back(e);
    endtask

    // Present the head of each requester queue on DUT A.
    task automatic drive();
        a_valid[0]   = (q0.size() != 0);
        a_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        a_last[0]    = (q0.size() != 0) ? q0[0][8]   : 1'b0;
        a_valid[1]   = (q1.size() != 0);
        a_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        a_last[1]    = (q1.size() != 0) ? q1[0][8]   : 1'b0;
    endtask

    // One clock: sample handshakes before the edge, update requesters #1 after.
    task automatic tick();
        @(negedge clk);
        acc = a_ready & a_valid;
        @(posedge clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor for DUT A.
    always @(negedge clk) begin
        cyc_a++;
        if (rst_n && a_wr) begin
            n_checks++;
            if (exp_a.size() == 0) begin
                n_errors++;
                $display("FAIL strobe_a: got unexpected byte %02h expected no strobe", a_tx_data);
            end else begin
                ea = exp_a.pop_front();
                if (a_tx_data !== ea.data || a_grant !== 2'(1 << ea.owner) ||
                    (ea.gap != 0 && (cyc_a - last_a) != ea.gap)) begin
                    n_errors++;
                    $display("FAIL strobe_a: got data %02h grant %b gap %0d expected data %02h owner %0d gap %0d",
                             a_tx_data, a_grant, cyc_a - last_a, ea.data, ea.owner, ea.gap);
                end
            end
            last_a = cyc_a;
        end
    end

    // Scoreboard monitor for DUT B.
    always @(negedge clk) begin
        cyc_b++;
        if (rst_n && b_wr) begin
            n_checks++;
            if (exp_b.size() == 0) begin
                n_errors++;
                $display("FAIL strobe_b: got unexpected byte %02h expected no strobe", b_tx_data);
            end else begin
                eb = exp_b.pop_front();
                cnt_b[eb.owner]++;
                if (b_tx_data !== eb.data || b_grant !== 4'(1 << eb.owner) ||
                    (eb.gap != 0 && (cyc_b - last_b) != eb.gap)) begin
                    n_errors++;
                    $display("FAIL strobe_b: got data %02h grant %b gap %0d expected data %02h owner %0d gap %0d",
                             b_tx_data, b_grant, cyc_b - last_b, eb.data, eb.owner, eb.gap);
                end
            end
            last_b = cyc_b;
        end
    end

    initial begin
        int unsigned n;
        rst_n      = 1'b0;
        tx_ready   = 1'b1;
        b_tx_ready = 1'b1;
        b_valid    = 4'h0;
        b_last     = 4'hF;
        b_data     = 32'hC3C2_C1C0;
        for (int i = 0; i < 4; i++) cnt_b[i] = 0;
        drive();
        #3;
        chk("rst_grant", 32'(a_grant), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_wr", 32'(a_wr), 0);
        chk("rst_tx_data", 32'(a_tx_data), 0);
        chk("rst_timeout", 32'(a_tevt), 0);
        chk("rst_grant_b", 32'(b_grant), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-byte message.
        q0.push_back({1'b1, 8'h41});
        push_a(8'h41, 0, 0);
        drive();
        tick();
        chk("t1_grant_c1", 32'(a_grant), 32'h1);
        chk("t1_busy_c1", 32'(a_busy), 1);
        chk("t1_ready_c1", 32'(a_ready), 32'h1);
        tick();
        chk("t1_wr_c2", 32'(a_wr), 1);
        chk("t1_data_c2", 32'(a_tx_data), 32'h41);
        tick();
        chk("t1_grant_c3", 32'(a_grant), 0);
        chk("t1_busy_c3", 32'(a_busy), 0);
        chk("t1_wr_c3", 32'(a_wr), 0);
        chk("t1_data_hold", 32'(a_tx_data), 32'h41);

        // Two competing 3-byte messages, then requester 0 again.
        do_reset();
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA1});
        q0.push_back({1'b1, 8'hA2}); q0.push_back({1'b1, 8'hA8});
        q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b0, 8'hB1});
        q1.push_back({1'b1, 8'hB2});
        push_a(8'hA0, 0, 0); push_a(8'hA1, 0, 2); push_a(8'hA2, 0, 2);
        push_a(8'hB0, 1, 3); push_a(8'hB1, 1, 2); push_a(8'hB2, 1, 2);
        push_a(8'hA8, 0, 3);
        drive();
        n = 0;
        while (exp_a.size() != 0 && n < 100) begin tick(); n++; end
        chk("t2_drained", 32'(exp_a.size()), 0);
        repeat (3) tick();
        chk("t2_idle_busy", 32'(a_busy), 0);

        // UART backpressure: no strobe, no timeout.
        q0.push_back({1'b1, 8'h5A});
        push_a(8'h5A, 0, 0);
        tx_ready = 1'b0;
        drive();
        repeat (10) begin
            tick();
            chk("t3_no_wr", 32'(a_wr), 0);
            chk("t3_no_timeout", 32'(a_tevt), 0);
        end
        chk("t3_grant_held", 32'(a_grant), 32'h1);
        tx_ready = 1'b1;
        tick();
        chk("t3_wr", 32'(a_wr), 1);
        chk("t3_data", 32'(a_tx_data), 32'h5A);
        repeat (2) tick();

        // Owner goes idle mid-message; requester 1 waits for the timeout.
        q0.push_back({1'b0, 8'h77});
        push_a(8'h77, 0, 0);
        drive();
        tick();
        tick();
        chk("t4_wr", 32'(a_wr), 1);
        q1.push_back({1'b1, 8'h33});
        push_a(8'h33, 1, 0);
        drive();
        tick();
        n = 0;
        while (!a_tevt && n < 300) begin tick(); n++; end
        chk("t4_timeout_latency", n, 255);
        chk("t4_grant_revoked", 32'(a_grant), 0);
        chk("t4_busy_revoked", 32'(a_busy), 0);
        tick();
        chk("t4_evt_one_cycle", 32'(a_tevt), 0);
        chk("t4_next_grant", 32'(a_grant), 32'h2);
        repeat (3) tick();
        chk("t4_done", 32'(a_busy), 0);

        // Reset during GAP of a multi-byte message.
        q0.push_back({1'b0, 8'hC1}); q0.push_back({1'b0, 8'hC2});
        q0.push_back({1'b1, 8'hC3});
        drive();
        n = 0;
        while (!a_wr && n < 10) begin tick(); n++; end
        chk("t5_first_wr", 32'(a_wr), 1);
        chk("t5_first_data", 32'(a_tx_data), 32'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(a_grant), 0);
        chk("t5_async_busy", 32'(a_busy), 0);
        chk("t5_async_wr", 32'(a_wr), 0);
        chk("t5_async_data", 32'(a_tx_data), 0);
        chk("t5_async_ready", 32'(a_ready), 0);
        q0.delete();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("t5_no_wr", 32'(a_wr), 0);
        end

        // Four always-valid single-byte requesters on DUT B.
        for (int r = 0; r < 8; r++) begin
            push_b(8'hC0 + 8'(r % 4), r % 4, (r == 0) ? 0 : 3);
        end
        b_valid = 4'hF;
        repeat (24) tick();
        b_valid = 4'h0;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) chk("t6_bytes_per_req", cnt_b[i], 2);

        chk("end_exp_a_empty", 32'(exp_a.size()), 0);
        chk("end_exp_b_empty", 32'(exp_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_arb
